// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
// Shared definitions for the instruction encoder and the control decoder:
// mnemonic codes, opcode/funct constants, field widths, FSM state type and
// small packing helpers. Both blocks import this package so that the
// encodings can never drift apart.
// -----------------------------------------------------------------------------
package instr_enc_pkg;

    // Field widths of the 32-bit instruction word and the session interface.
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 30;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned MNEM_W  = 5;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TGT_W   = 26;

    // Mnemonic codes presented on mnem_i; any other value is illegal.
    typedef enum logic [MNEM_W-1:0] {
        MN_ADD   = 5'd0,
        MN_SUB   = 5'd1,
        MN_AND   = 5'd2,
        MN_OR    = 5'd3,
        MN_SLT   = 5'd4,
        MN_LW    = 5'd5,
        MN_SW    = 5'd6,
        MN_J     = 5'd7,
        MN_BLE   = 5'd8,
        MN_BLTZ  = 5'd9,
        MN_BEQ   = 5'd10,
        MN_BNE   = 5'd11,
        MN_ADDI  = 5'd12,
        MN_SLTIU = 5'd13,
        MN_SLTI  = 5'd14,
        MN_ORI   = 5'd15,
        MN_LUI   = 5'd16
    } mnem_e;

    // Primary opcodes.
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BLE   = 6'h06;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'h01;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;

    // R-type function codes.
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    // Word emitted in place of an illegal mnemonic.
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    // Session controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [INSTR_W-1:0] pack_r(
        input logic [REG_W-1:0]   rs,
        input logic [REG_W-1:0]   rt,
        input logic [REG_W-1:0]   rd,
        input logic [FUNCT_W-1:0] funct
    );
        return {OP_RTYPE, rs, rt, rd, {SHAMT_W{1'b0}}, funct};
    endfunction

    function automatic logic [INSTR_W-1:0] pack_i(
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [IMM_W-1:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [INSTR_W-1:0] pack_j(
        input logic [OP_W-1:0]  op,
        input logic [TGT_W-1:0] target
    );
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Purely combinational field packer: turns a mnemonic plus register,
// immediate and target fields into a 32-bit instruction word.
//
// Ports:
//   mnem_i     mnemonic code (instr_enc_pkg::mnem_e values)
//   rs_i/rt_i/rd_i register fields
//   imm_i      16-bit immediate
//   target_i   26-bit jump target
//   word_o     packed instruction word (nop for an illegal mnemonic)
//   illegal_o  high when mnem_i is not a known mnemonic
// -----------------------------------------------------------------------------
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [MNEM_W-1:0]  mnem_i,
    input  logic [REG_W-1:0]   rs_i,
    input  logic [REG_W-1:0]   rt_i,
    input  logic [REG_W-1:0]   rd_i,
    input  logic [IMM_W-1:0]   imm_i,
    input  logic [TGT_W-1:0]   target_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               illegal_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        word_o    = NOP_WORD;
        illegal_o = 1'b0;
        case (mnem_e'(mnem_i))
            MN_ADD:   word_o = pack_r(rs_i, rt_i, rd_i, FN_ADD);
            MN_SUB:   word_o = pack_r(rs_i, rt_i, rd_i, FN_SUB);
            MN_AND:   word_o = pack_r(rs_i, rt_i, rd_i, FN_AND);
            MN_OR:    word_o = pack_r(rs_i, rt_i, rd_i, FN_OR);
            MN_SLT:   word_o = pack_r(rs_i, rt_i, rd_i, FN_SLT);
            MN_LW:    word_o = pack_i(OP_LW,    rs_i, rt_i, imm_i);
            MN_SW:    word_o = pack_i(OP_SW,    rs_i, rt_i, imm_i);
            MN_BLE:   word_o = pack_i(OP_BLE,   rs_i, rt_i, imm_i);
            MN_BEQ:   word_o = pack_i(OP_BEQ,   rs_i, rt_i, imm_i);
            MN_BNE:   word_o = pack_i(OP_BNE,   rs_i, rt_i, imm_i);
            MN_ADDI:  word_o = pack_i(OP_ADDI,  rs_i, rt_i, imm_i);
            MN_SLTIU: word_o = pack_i(OP_SLTIU, rs_i, rt_i, imm_i);
            MN_SLTI:  word_o = pack_i(OP_SLTI,  rs_i, rt_i, imm_i);
            MN_ORI:   word_o = pack_i(OP_ORI,   rs_i, rt_i, imm_i);
            // bltz compares rs against zero, so the rt slot is forced to 0.
            MN_BLTZ:  word_o = pack_i(OP_BLTZ,  rs_i, {REG_W{1'b0}}, imm_i);
            // lui has no source register.
            MN_LUI:   word_o = pack_i(OP_LUI,   {REG_W{1'b0}}, rt_i, imm_i);
            MN_J:     word_o = pack_j(OP_J, target_i);
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Streams encoded instruction words into an instruction-memory write port.
// A session is opened by start_i with a base word address and a word count;
// each accepted request is packed by instr_pack and held in a one-entry
// output register together with its address until the downstream port takes
// it. Illegal mnemonics are replaced by a nop so the word count is preserved.
//
// Configuration macro: INSTR_ENCODER_CHECKSUM_EN adds csum_o, the XOR of all
// words that completed the output handshake since the last start_i.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 one-cycle session start (ignored unless idle)
//   base_addr_i, len_i      session base word address and word count
//   in_valid_i/in_ready_o   request handshake
//   mnem_i, rs_i, rt_i, rd_i, imm_i, target_i   request fields
//   instr_valid_o/instr_ready_i  output handshake
//   instr_o, addr_o         encoded word and its word address
//   busy_o                  session active
//   done_o                  one-cycle pulse at session end
//   err_o                   sticky illegal-mnemonic flag
//   csum_o                  running XOR checksum (checksum build only)
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_enc_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [MNEM_W-1:0]  mnem_i,
    input  logic [REG_W-1:0]   rs_i,
    input  logic [REG_W-1:0]   rt_i,
    input  logic [REG_W-1:0]   rd_i,
    input  logic [IMM_W-1:0]   imm_i,
    input  logic [TGT_W-1:0]   target_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [INSTR_W-1:0] csum_o
`endif
);

    state_e state_q, state_d;

    logic [LEN_W-1:0]   len_q,         len_d;
    logic [LEN_W-1:0]   cnt_q,         cnt_d;       // words accepted this session
    logic [ADDR_W-1:0]  next_addr_q,   next_addr_d; // address for the next accepted word
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instr_q,       instr_d;
    logic [ADDR_W-1:0]  addr_q,        addr_d;
    logic               err_q,         err_d;
    logic               done_len0_q,   done_len0_d; // done pulse for an empty session

    logic [INSTR_W-1:0] pack_word;
    logic               pack_illegal;

    logic start_ok;
    logic in_fire;
    logic out_fire;
    logic last_accept;

    instr_pack u_pack (
        .mnem_i    (mnem_i),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .rd_i      (rd_i),
        .imm_i     (imm_i),
        .target_i  (target_i),
        .word_o    (pack_word),
        .illegal_o (pack_illegal)
    );

    assign start_ok    = (state_q == ST_IDLE) && start_i;
    assign out_fire    = instr_valid_q && instr_ready_i;
    assign in_fire     = in_valid_i && in_ready_o;
    assign last_accept = in_fire && ((cnt_q + LEN_W'(1)) == len_q);

    // ---------------------------------------------------------------- FSM --
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok && (len_i != '0)) state_d = ST_RUN;
            ST_RUN:   if (last_accept)               state_d = ST_DRAIN;
            // The last word is in the output register for the whole of DRAIN.
            ST_DRAIN: if (out_fire)                  state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // A full output register can still take a new word if it is being
        // drained in the same cycle, which gives one word per cycle.
        in_ready_o = (state_q == ST_RUN) && (!instr_valid_q || instr_ready_i);
        busy_o     = (state_q != ST_IDLE);
        done_o     = done_len0_q || ((state_q == ST_DRAIN) && out_fire);
    end

    // ----------------------------------------------------------- datapath --
    always_comb begin
        len_d         = len_q;
        cnt_d         = cnt_q;
        next_addr_d   = next_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        addr_d        = addr_q;
        err_d         = err_q;
        done_len0_d   = 1'b0;

        if (start_ok) begin
            len_d       = len_i;
            cnt_d       = '0;
            next_addr_d = base_addr_i;
            err_d       = 1'b0;
            done_len0_d = (len_i == '0);
        end

        if (out_fire) begin
            instr_valid_d = 1'b0;
        end

        // Loading wins over draining: a word accepted while the previous one
        // leaves keeps the register full.
        if (in_fire) begin
            instr_valid_d = 1'b1;
            instr_d       = pack_word;
            addr_d        = next_addr_q;
            next_addr_d   = next_addr_q + ADDR_W'(1);
            cnt_d         = cnt_q + LEN_W'(1);
            if (pack_illegal) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: the output word register is reset as well as the control bits,
        // because instr_o/addr_o must read zero out of reset.
        if (rst_i) begin
            len_q         <= '0;
            cnt_q         <= '0;
            next_addr_q   <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            addr_q        <= '0;
            err_q         <= 1'b0;
            done_len0_q   <= 1'b0;
        end else begin
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            next_addr_q   <= next_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            addr_q        <= addr_d;
            err_q         <= err_d;
            done_len0_q   <= done_len0_d;
        end
    end

    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign addr_o        = addr_q;
    assign err_o         = err_q;

    // ----------------------------------------------------------- checksum --
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [INSTR_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_ok) begin
            csum_d = '0;
        end else if (out_fire) begin
            csum_d = csum_q ^ instr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    // Fold in the word completing its handshake now so the value already
    // covers the last word in the done_o cycle.
    assign csum_o = out_fire ? (csum_q ^ instr_q) : csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Directed bench for instr_encoder. Stimulus pushes the hand-computed word,
// address and end-of-session flag into a scoreboard queue when a request is
// accepted; an independent monitor pops and compares on every output
// handshake. Define INSTR_ENCODER_CHECKSUM_EN to also exercise csum_o.
// -----------------------------------------------------------------------------
module tb_instr_encoder;
    import instr_enc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [29:0] base_addr_i;
    logic [7:0]  len_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  mnem_i;
    logic [4:0]  rs_i;
    logic [4:0]  rt_i;
    logic [4:0]  rd_i;
    logic [15:0] imm_i;
    logic [25:0] target_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [29:0] addr_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0] csum_o;
`endif

    always #5 clk_i = ~clk_i;

    instr_encoder dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .len_i         (len_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .mnem_i        (mnem_i),
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .rd_i          (rd_i),
        .imm_i         (imm_i),
        .target_i      (target_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .addr_o        (addr_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
`ifdef INSTR_ENCODER_CHECKSUM_EN
        ,
        .csum_o        (csum_o)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [29:0] addr;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          errors   = 0;
    int          checks   = 0;
    int          done_cnt = 0;
    logic [29:0] exp_addr;
    logic [31:0] csum_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every word leaving the output port.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
            if (!rst_i && instr_valid_o && instr_ready_i) begin
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("instr_o", instr_o, e.instr);
                    check("addr_o", 32'(addr_o), 32'(e.addr));
                    check("done_at_last", 32'(done_o), 32'(e.last));
`ifdef INSTR_ENCODER_CHECKSUM_EN
                    csum_model = csum_model ^ e.instr;
                    check("csum_o", csum_o, csum_model);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // All driving tasks are entered and left 1 time unit after a rising edge.
    task automatic start_session(input logic [29:0] base, input logic [7:0] len);
        start_i     = 1'b1;
        base_addr_i = base;
        len_i       = len;
        exp_addr    = base;
        csum_model  = '0;
        @(posedge clk_i); #1;
        start_i     = 1'b0;
    endtask

    task automatic send(input logic [4:0] mnem, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [31:0] exp_word, input logic last);
        exp_t e;
        bit   acc = 1'b0;
        mnem_i = mnem; rs_i = rs; rt_i = rt; rd_i = rd; imm_i = imm; target_i = tgt;
        in_valid_i = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                acc     = 1'b1;
                e.instr = exp_word;
                e.addr  = exp_addr;
                e.last  = last;
                exp_q.push_back(e);
                exp_addr = exp_addr + 30'd1;
            end
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b0;
        check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (!busy_o) break;
        end
        check("idle_timeout", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        int d0;
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0;
        in_valid_i = 1'b0; mnem_i = '0; rs_i = '0; rt_i = '0; rd_i = '0;
        imm_i = '0; target_i = '0; instr_ready_i = 1'b1;
        exp_addr = '0; csum_model = '0;

        // Reset values.
        @(posedge clk_i);
        @(negedge clk_i);
        check("reset_ctrl", 32'({in_ready_o, instr_valid_o, busy_o, done_o, err_o}), 32'd0);
        check("reset_instr", instr_o, 32'd0);
        check("reset_addr", 32'(addr_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Single addi, one-cycle latency, done with the handshake.
        d0 = done_cnt;
        start_session(30'h100, 8'd1);
        send(MN_ADDI, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 32'h2022_0005, 1'b1);
        check("latency_valid", 32'(instr_valid_o), 32'd1);
        check("latency_instr", instr_o, 32'h2022_0005);
        check("latency_addr", 32'(addr_o), 32'h100);
        wait_idle();
        check("done_count_1", done_cnt - d0, 32'd1);

        // R-type, jump and lui back to back.
        start_session(30'h200, 8'd3);
        send(MN_SUB, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0, 32'h0064_2822, 1'b0);
        send(MN_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0040, 32'h0800_0040, 1'b0);
        send(MN_LUI, 5'd9, 5'd7, 5'd0, 16'h1234, 26'h0, 32'h3C07_1234, 1'b1);
        wait_idle();

        // Backpressure after the first word.
        instr_ready_i = 1'b0;
        start_session(30'h100, 8'd4);
        send(MN_ORI, 5'd0, 5'd1, 5'd0, 16'h00AA, 26'h0, 32'h3401_00AA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("hold_instr", instr_o, 32'h3401_00AA);
            check("hold_addr", 32'(addr_o), 32'h100);
            check("hold_in_ready", 32'(in_ready_o), 32'd0);
        end
        @(posedge clk_i); #1;
        instr_ready_i = 1'b1;
        send(MN_LW, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 32'h8C43_0010, 1'b0);
        send(MN_SW, 5'd2, 5'd3, 5'd0, 16'h0014, 26'h0, 32'hAC43_0014, 1'b0);
        send(MN_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022_FFFF, 1'b1);
        wait_idle();

        // Illegal mnemonic mid-session: nop emitted, err sticky.
        start_session(30'h300, 8'd3);
        send(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820, 1'b0);
        send(5'd31, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 32'h0000_0000, 1'b0);
        check("err_set", 32'(err_o), 32'd1);
        send(MN_AND, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h0085_3024, 1'b1);
        wait_idle();
        check("err_sticky", 32'(err_o), 32'd1);

        // Empty session: done pulse, never busy, err cleared.
        d0 = done_cnt;
        start_session(30'h0, 8'd0);
        @(negedge clk_i);
        check("len0_done", 32'(done_o), 32'd1);
        check("len0_busy", 32'(busy_o), 32'd0);
        check("err_cleared", 32'(err_o), 32'd0);
        @(negedge clk_i);
        check("len0_done_clr", 32'(done_o), 32'd0);
        check("len0_busy2", 32'(busy_o), 32'd0);
        check("len0_done_count", done_cnt - d0, 32'd1);
        @(posedge clk_i); #1;

        // Address wrap.
        start_session(30'h3FFF_FFFF, 8'd2);
        send(MN_SLTI, 5'd0, 5'd1, 5'd0, 16'h0007, 26'h0, 32'h2801_0007, 1'b0);
        send(MN_BLTZ, 5'd2, 5'd9, 5'd0, 16'h0008, 26'h0, 32'h0440_0008, 1'b1);
        wait_idle();

        // Reset wins over start in the same cycle.
        rst_i = 1'b1; start_i = 1'b1; len_i = 8'd5;
        @(posedge clk_i); #1;
        rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check("rst_over_start", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;

        // Reset mid-RUN with a pending word.
        instr_ready_i = 1'b0;
        start_session(30'h40, 8'd3);
        send(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820, 1'b0);
        d0 = done_cnt;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_q.delete();
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        check("midrst_ctrl", 32'({in_ready_o, instr_valid_o, busy_o, done_o, err_o}), 32'd0);
        check("midrst_instr", instr_o, 32'd0);
        check("midrst_addr", 32'(addr_o), 32'd0);
        repeat (3) @(negedge clk_i);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        @(posedge clk_i); #1;

`ifdef INSTR_ENCODER_CHECKSUM_EN
        // add 0,0,0 -> 0x20, sub 0,0,0 -> 0x22, XOR = 0x02.
        start_session(30'h0, 8'd2);
        send(MN_ADD, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0000_0020, 1'b0);
        send(MN_SUB, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0000_0022, 1'b1);
        wait_idle();
        check("csum_final", csum_o, 32'h0000_0002);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
